// File: rtl/wbs_ram_pkg.sv
// Shared definitions for the wbs_ram Wishbone slave: bus widths, FSM states
// and the address-window decode helper.
package wbs_ram_pkg;

    localparam int unsigned WB_SEL_W = 4;
    localparam int unsigned WB_DAT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // True when addr lies in [base, base + 4*2^aw); 33-bit math so a window
    // ending at the top of the address space does not wrap.
    function automatic logic addr_in_window(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input int unsigned aw);
        logic [32:0] lim;
        lim = {1'b0, base} + (33'd4 << aw);
        return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < lim);
    endfunction

endpackage

// File: rtl/wbs_ram_if.sv
// Wishbone B4 classic data-bus bundle between the memory stage (master) and
// the RAM slave; signal names are from the slave's point of view.
interface wbs_ram_if;
    import wbs_ram_pkg::*;

    logic                wbs_cyc_i;
    logic                wbs_stb_i;
    logic                wbs_we_i;
    logic [WB_SEL_W-1:0] wbs_sel_i;
    logic [31:0]         wbs_addr_i;
    logic [WB_DAT_W-1:0] wbs_dat_i;
    logic [WB_DAT_W-1:0] wbs_dat_o;
    logic                wbs_ack_o;
    logic                wbs_err_o;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_addr_i, wbs_dat_i,
        output wbs_dat_o, wbs_ack_o, wbs_err_o
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_addr_i, wbs_dat_i,
        input  wbs_dat_o, wbs_ack_o, wbs_err_o
    );

endinterface

// File: rtl/wbs_ram_mem.sv
// Single-port word array with byte-lane write enables and a registered read
// port; reset and clear only affect the read register, never the contents.
module wbs_ram_mem
    import wbs_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rd_en_i,
    input  logic                  rd_clr_i,
    input  logic                  wr_en_i,
    input  logic [WB_SEL_W-1:0]   sel_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WB_DAT_W-1:0]   wdata_i,
    output logic [WB_DAT_W-1:0]   rdata_o
);

    logic [WB_DAT_W-1:0] mem_q [0:(1 << ADDR_WIDTH)-1];
    logic [WB_DAT_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < WB_SEL_W; i++) begin
            if (wr_en_i && sel_i[i]) begin
                mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (rd_clr_i) begin
            rdata_q <= '0;
        end else if (rd_en_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/wbs_ram.sv
// Wishbone B4 classic RAM slave: window decode, programmable wait states and
// exactly one registered ack/err pulse per accepted, non-aborted cycle.
module wbs_ram
    import wbs_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic     clk_i,
    input  logic     rst_i,
    wbs_ram_if.slave wbs
);

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] widx_q, widx_d;
    logic                  we_q, we_d;
    logic [WB_SEL_W-1:0]   sel_q, sel_d;
    logic [WB_DAT_W-1:0]   wdat_q, wdat_d;
    logic                  hit_q, hit_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;

    logic                  req;
    logic                  hit_now;
    logic                  enter_resp;
    logic                  mem_rd_en;
    logic                  mem_rd_clr;
    logic                  mem_wr_en;
    logic [WB_DAT_W-1:0]   mem_rdata;

    assign req     = wbs.wbs_cyc_i && wbs.wbs_stb_i;
    assign hit_now = addr_in_window(wbs.wbs_addr_i, BASE_ADDR, ADDR_WIDTH)
                     && (wbs.wbs_addr_i[1:0] == 2'b00)
                     && (wbs.wbs_sel_i != '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        widx_d  = widx_q;
        we_d    = we_q;
        sel_d   = sel_q;
        wdat_d  = wdat_q;
        hit_d   = hit_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    widx_d  = wbs.wbs_addr_i[ADDR_WIDTH+1:2];
                    we_d    = wbs.wbs_we_i;
                    sel_d   = wbs.wbs_sel_i;
                    wdat_d  = wbs.wbs_dat_i;
                    hit_d   = hit_now;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = (WAIT_STATES != 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (!wbs.wbs_cyc_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The read is launched on the edge entering RESP so data and ack appear
    // together; widx_d already points at the request word on that edge.
    always_comb begin
        enter_resp = (state_d == ST_RESP);
        ack_d      = enter_resp && hit_d;
        err_d      = enter_resp && !hit_d;
        mem_rd_en  = enter_resp && hit_d && !we_d;
        mem_rd_clr = enter_resp && !hit_d;
        mem_wr_en  = (state_q == ST_RESP) && hit_q && we_q && !rst_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            widx_q  <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            wdat_q  <= '0;
            hit_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            widx_q  <= widx_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            wdat_q  <= wdat_d;
            hit_q   <= hit_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    wbs_ram_mem #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .rd_en_i  (mem_rd_en),
        .rd_clr_i (mem_rd_clr),
        .wr_en_i  (mem_wr_en),
        .sel_i    (sel_q),
        .addr_i   (widx_d),
        .wdata_i  (wdat_q),
        .rdata_o  (mem_rdata)
    );

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_err_o = err_q;
    assign wbs.wbs_dat_o = mem_rdata;

endmodule

// File: tb/tb_wbs_ram.sv
// Bench for wbs_ram: three instances (0/1/3 wait states, different bases)
// driven through one shared master; vector table, corner sequences, random.
module tb_wbs_ram;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [3:0]  sel = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdat = '0;
    int          dsel = 1;

    logic        ack, err;
    logic [31:0] rdat;

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl [3][16];

    always #5 clk = ~clk;

    wbs_ram_if bus0 ();
    wbs_ram_if bus1 ();
    wbs_ram_if bus2 ();

    assign bus0.wbs_cyc_i = cyc && (dsel == 0);
    assign bus0.wbs_stb_i = stb && (dsel == 0);
    assign bus0.wbs_we_i = we;
    assign bus0.wbs_sel_i = sel;
    assign bus0.wbs_addr_i = addr;
    assign bus0.wbs_dat_i = wdat;
    assign bus1.wbs_cyc_i = cyc && (dsel == 1);
    assign bus1.wbs_stb_i = stb && (dsel == 1);
    assign bus1.wbs_we_i = we;
    assign bus1.wbs_sel_i = sel;
    assign bus1.wbs_addr_i = addr;
    assign bus1.wbs_dat_i = wdat;
    assign bus2.wbs_cyc_i = cyc && (dsel == 2);
    assign bus2.wbs_stb_i = stb && (dsel == 2);
    assign bus2.wbs_we_i = we;
    assign bus2.wbs_sel_i = sel;
    assign bus2.wbs_addr_i = addr;
    assign bus2.wbs_dat_i = wdat;

    always_comb begin
        ack  = bus1.wbs_ack_o;
        err  = bus1.wbs_err_o;
        rdat = bus1.wbs_dat_o;
        case (dsel)
            0: begin ack = bus0.wbs_ack_o; err = bus0.wbs_err_o; rdat = bus0.wbs_dat_o; end
            2: begin ack = bus2.wbs_ack_o; err = bus2.wbs_err_o; rdat = bus2.wbs_dat_o; end
            default: ;
        endcase
    end

    wbs_ram #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0000_2000), .WAIT_STATES(0))
        dut0 (.clk_i(clk), .rst_i(rst), .wbs(bus0));
    wbs_ram #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(1))
        dut1 (.clk_i(clk), .rst_i(rst), .wbs(bus1));
    wbs_ram #(.ADDR_WIDTH(10), .BASE_ADDR(32'h8000_0000), .WAIT_STATES(3))
        dut2 (.clk_i(clk), .rst_i(rst), .wbs(bus2));

    function automatic logic [31:0] base_of(input int d);
        case (d)
            0:       return 32'h0000_2000;
            1:       return 32'h0000_0000;
            default: return 32'h8000_0000;
        endcase
    endfunction

    function automatic int wait_of(input int d);
        case (d)
            0:       return 0;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", nm, act, exp);
        end
    endtask

    // One complete classic cycle; request fields are scrambled after the
    // accept edge to show the slave works from its latched copy.
    task automatic access(input string nm, input int d, input logic w, input logic [3:0] s,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic got_ack, output logic got_err,
                          output logic [31:0] got_dat, output int lat);
        dsel = d;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; addr = a; wdat = wd;
        @(posedge clk); #1;
        stb = 1'b0; we = 1'($urandom); sel = 4'($urandom); addr = $urandom; wdat = $urandom;
        got_ack = 1'b0; got_err = 1'b0; got_dat = '0; lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (ack || err) begin
                got_ack = ack; got_err = err; got_dat = rdat; lat = n;
                break;
            end
        end
        @(posedge clk); #1;
        cyc = 1'b0;
        @(negedge clk);
        check({nm, "_pulse_width"}, 32'(ack || err), 32'd0);
    endtask

    task automatic xfer(input string nm, input int d, input logic w, input logic [3:0] s,
                        input logic [31:0] a, input logic [31:0] wd, input logic exp_ack,
                        input logic chk_dat, input logic [31:0] exp_dat);
        logic ga, ge;
        logic [31:0] gd;
        int lat;
        access(nm, d, w, s, a, wd, ga, ge, gd, lat);
        check({nm, "_latency"}, 32'(lat), 32'(1 + wait_of(d)));
        check({nm, "_ack"}, 32'(ga), 32'(exp_ack));
        check({nm, "_err"}, 32'(ge), 32'(!exp_ack));
        if (chk_dat) check({nm, "_dat"}, gd, exp_dat);
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic        exp_ack;
        logic        chk_dat;
        logic [31:0] exp_dat;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [13];
        logic        seen;
        logic [31:0] b;

        vt[0]  = '{1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0};
        vt[1]  = '{1'b0, 4'hF, 32'h0000_0010, 32'h0,         1'b1, 1'b1, 32'hDEAD_BEEF};
        vt[2]  = '{1'b1, 4'h4, 32'h0000_0010, 32'h00AA_0000, 1'b1, 1'b0, 32'h0};
        vt[3]  = '{1'b0, 4'hF, 32'h0000_0010, 32'h0,         1'b1, 1'b1, 32'hDEAA_BEEF};
        vt[4]  = '{1'b0, 4'hF, 32'h0000_1000, 32'h0,         1'b0, 1'b1, 32'h0};
        vt[5]  = '{1'b1, 4'hF, 32'h0000_0012, 32'h5555_5555, 1'b0, 1'b1, 32'h0};
        vt[6]  = '{1'b0, 4'hF, 32'h0000_0010, 32'h0,         1'b1, 1'b1, 32'hDEAA_BEEF};
        vt[7]  = '{1'b1, 4'hF, 32'h0000_0FFC, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0};
        vt[8]  = '{1'b0, 4'hF, 32'h0000_0FFC, 32'h0,         1'b1, 1'b1, 32'hCAFE_F00D};
        vt[9]  = '{1'b1, 4'h0, 32'h0000_0014, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0};
        vt[10] = '{1'b0, 4'h0, 32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'h0};
        vt[11] = '{1'b1, 4'h3, 32'h0000_0010, 32'h0000_1234, 1'b1, 1'b0, 32'h0};
        vt[12] = '{1'b0, 4'hF, 32'h0000_0010, 32'h0,         1'b1, 1'b1, 32'hDEAA_1234};

        // Reset state of every instance
        repeat (3) @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            dsel = d;
            @(negedge clk);
            check($sformatf("reset%0d_ack", d), 32'(ack), 32'd0);
            check($sformatf("reset%0d_err", d), 32'(err), 32'd0);
            check($sformatf("reset%0d_dat", d), rdat, 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            xfer($sformatf("vec%0d", i), 1, vt[i].we, vt[i].sel, vt[i].addr, vt[i].wdat,
                 vt[i].exp_ack, vt[i].chk_dat, vt[i].exp_dat);
        end

        // Abort in the second wait cycle of a 3-wait-state write
        b = base_of(2);
        xfer("abort_pre", 2, 1'b1, 4'hF, b + 32'h20, 32'hAAAA_5555, 1'b1, 1'b0, 32'h0);
        dsel = 2;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; addr = b + 32'h20; wdat = 32'h1234_5678;
        @(posedge clk); #1;
        stb = 1'b0;
        @(posedge clk); #1;
        cyc = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | ack | err;
        end
        check("abort_no_term", 32'(seen), 32'd0);
        xfer("abort_read", 2, 1'b0, 4'hF, b + 32'h20, 32'h0, 1'b1, 1'b1, 32'hAAAA_5555);

        // Reset asserted in the cycle before RESP of a write
        xfer("rst_pre_w", 1, 1'b1, 4'hF, 32'h30, 32'h1111_1111, 1'b1, 1'b0, 32'h0);
        xfer("rst_pre_r", 1, 1'b0, 4'hF, 32'h30, 32'h0, 1'b1, 1'b1, 32'h1111_1111);
        dsel = 1;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; addr = 32'h30; wdat = 32'h2222_2222;
        @(posedge clk); #1;
        stb = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; cyc = 1'b0;
        @(negedge clk);
        check("rst_mid_ack", 32'(ack), 32'd0);
        check("rst_mid_err", 32'(err), 32'd0);
        check("rst_mid_dat", rdat, 32'd0);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | ack | err;
        end
        check("rst_mid_no_term", 32'(seen), 32'd0);
        xfer("rst_post_r", 1, 1'b0, 4'hF, 32'h30, 32'h0, 1'b1, 1'b1, 32'h1111_1111);

        // Zero wait states, strobe held for three back-to-back reads
        b = base_of(0);
        xfer("b2b_pre", 0, 1'b1, 4'hF, b + 32'h8, 32'h0BAD_F00D, 1'b1, 1'b0, 32'h0);
        dsel = 0;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; addr = b + 32'h8;
        @(posedge clk);
        seen = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            #1;
            if (c == 5) begin
                cyc = 1'b0; stb = 1'b0;
            end
            @(negedge clk);
            check($sformatf("b2b_ack_c%0d", c), 32'(ack), 32'((c % 2 == 1) && (c <= 5)));
            if ((c % 2 == 1) && (c <= 5)) check($sformatf("b2b_dat_c%0d", c), rdat, 32'h0BAD_F00D);
            seen = seen | err;
            @(posedge clk);
        end
        check("b2b_no_err", 32'(seen), 32'd0);

        // Random traffic against a word-array reference model
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 16; k++) begin
                mdl[d][k] = $urandom;
                xfer("rinit", d, 1'b1, 4'hF, base_of(d) + 32'h100 + 32'(4 * k), mdl[d][k],
                     1'b1, 1'b0, 32'h0);
            end
        end
        for (int i = 0; i < 60; i++) begin
            int               d, k, kind;
            logic             w, hit;
            logic [3:0]       s;
            logic [31:0]      a, wd, exp;
            longint unsigned  la, lb;
            d    = $urandom_range(0, 2);
            k    = $urandom_range(0, 15);
            w    = 1'($urandom_range(0, 1));
            s    = 4'($urandom_range(1, 15));
            wd   = $urandom;
            a    = base_of(d) + 32'h100 + 32'(4 * k);
            kind = $urandom_range(0, 9);
            case (kind)
                0: a = base_of(d) + 32'h1000 + 32'(4 * k);
                1: a = a + 32'($urandom_range(1, 3));
                2: s = 4'h0;
                3: a = base_of(d) - 32'h4 - 32'(4 * k);
                default: ;
            endcase
            la  = 64'(a);
            lb  = 64'(base_of(d));
            hit = (la >= lb) && (la < lb + 4096) && (a % 4 == 0) && (s != 0);
            exp = 32'h0;
            if (hit) begin
                k = int'((a - base_of(d) - 32'h100) / 4);
                if (w) begin
                    for (int ln = 0; ln < 4; ln++)
                        if (s[ln]) mdl[d][k][8*ln +: 8] = wd[8*ln +: 8];
                end else begin
                    exp = mdl[d][k];
                end
            end
            xfer($sformatf("rand%0d", i), d, w, s, a, wd, hit, !(hit && w), exp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
